// File: rtl/e_inv_sched_pkg.sv
// Shared types and constants for the modular-inverse scheduler.
// Imported by the interface, the arbiter and the scheduler top.
package e_inv_pkg;

   localparam int WIDTH_DEF = 256;
   localparam logic [WIDTH_DEF-1:0] ZERO_W = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/e_inv_sched_if.sv
// Requester and inverter signals of the scheduler bundled as one interface.
// slave is the scheduler's view; master is the surrounding environment's view.
interface e_inv_sched_if
   import e_inv_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int WIDTH = WIDTH_DEF
);
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] req_operand;
   logic [N_REQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]       rsp_data;
   logic                   rsp_err;
   logic                   busy;
   logic                   inv_start;
   logic [WIDTH-1:0]       inv_operand;
   logic [WIDTH-1:0]       inv_result;
   logic                   inv_done;

   modport slave (
      input  req, req_operand, inv_result, inv_done,
      output rsp_valid, rsp_data, rsp_err, busy, inv_start, inv_operand
   );

   modport master (
      output req, req_operand, inv_result, inv_done,
      input  rsp_valid, rsp_data, rsp_err, busy, inv_start, inv_operand
   );
endinterface

// File: rtl/e_inv_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
// Returns a one-hot grant, the granted index and whether any request is present.
module e_rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any_req
);
   logic             found;
   logic [IDX_W-1:0] cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IDX_W'((int'(ptr) + k) % N_REQ);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign any_req = |req;
endmodule

// File: rtl/e_inv_sched.sv
// Shares one modular-inverse datapath between N_REQ requesters with round-robin
// arbitration, zero-operand short-circuit and a watchdog on the inverter.
module e_inv_sched
   import e_inv_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int WIDTH   = WIDTH_DEF,
   parameter int TIMEOUT = 4096,
   parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic          clk,
   input  logic          reset,
   e_inv_sched_if.slave  bus
);
   localparam int               IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t           state_reg;
   logic [IDX_W-1:0] ptr_reg;
   logic [IDX_W-1:0] grant_idx_reg;
   logic [N_REQ-1:0] grant_oh_reg;
   logic [CNT_W-1:0] wdog_reg;
   logic [CNT_W-1:0] wdog_next;
   logic [N_REQ-1:0] rsp_valid_reg;
   logic [WIDTH-1:0] rsp_data_reg;
   logic             rsp_err_reg;
   logic             inv_start_reg;
   logic [WIDTH-1:0] inv_operand_reg;

   logic [N_REQ-1:0] arb_grant;
   logic [IDX_W-1:0] arb_idx;
   logic             arb_any;
   logic [WIDTH-1:0] operand_arr [N_REQ];
   logic [WIDTH-1:0] sel_operand;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
         assign operand_arr[gi] = bus.req_operand[gi*WIDTH +: WIDTH];
      end
   endgenerate

   e_rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req       (bus.req),
      .ptr       (ptr_reg),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any_req   (arb_any)
   );

   assign sel_operand = operand_arr[arb_idx];
   assign wdog_next   = wdog_reg + CNT_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         ptr_reg         <= '0;
         grant_idx_reg   <= '0;
         grant_oh_reg    <= '0;
         wdog_reg        <= '0;
         rsp_valid_reg   <= '0;
         rsp_data_reg    <= '0;
         rsp_err_reg     <= 1'b0;
         inv_start_reg   <= 1'b0;
         inv_operand_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (arb_any) begin
                  grant_idx_reg   <= arb_idx;
                  grant_oh_reg    <= arb_grant;
                  inv_operand_reg <= sel_operand;
                  wdog_reg        <= '0;
                  // No inverse of zero exists: answer at once without starting the inverter.
                  if (sel_operand == WIDTH'(ZERO_W)) begin
                     state_reg     <= RESP;
                     rsp_valid_reg <= arb_grant;
                     rsp_data_reg  <= '0;
                     rsp_err_reg   <= 1'b1;
                  end else begin
                     state_reg     <= RUN;
                     inv_start_reg <= 1'b1;
                  end
               end
            end
            RUN: begin
               wdog_reg <= wdog_next;
               if (bus.inv_done) begin
                  state_reg     <= RESP;
                  inv_start_reg <= 1'b0;
                  rsp_valid_reg <= grant_oh_reg;
                  rsp_data_reg  <= bus.inv_result;
                  rsp_err_reg   <= 1'b0;
               end else if (wdog_next == TIMEOUT_C) begin
                  state_reg     <= RESP;
                  inv_start_reg <= 1'b0;
                  rsp_valid_reg <= grant_oh_reg;
                  rsp_data_reg  <= '0;
                  rsp_err_reg   <= 1'b1;
               end
            end
            RESP: begin
               rsp_valid_reg <= '0;
               rsp_data_reg  <= '0;
               rsp_err_reg   <= 1'b0;
               wdog_reg      <= '0;
               ptr_reg       <= (grant_idx_reg == LAST_IDX) ? '0 : grant_idx_reg + IDX_W'(1);
               state_reg     <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.rsp_valid   = rsp_valid_reg;
   assign bus.rsp_data    = rsp_data_reg;
   assign bus.rsp_err     = rsp_err_reg;
   assign bus.inv_start   = inv_start_reg;
   assign bus.inv_operand = inv_operand_reg;
   assign bus.busy        = (state_reg != IDLE);
endmodule

// File: tb/tb_e_inv_sched.sv
// Directed bench for e_inv_sched: two instances (long and 16-cycle watchdog),
// each driven by an inverter stub with programmable done latency.
module tb_e_inv_sched;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   e_inv_sched_if #(.N_REQ(2), .WIDTH(256)) b0 ();
   e_inv_sched_if #(.N_REQ(2), .WIDTH(256)) b1 ();

   e_inv_sched #(.N_REQ(2), .WIDTH(256), .TIMEOUT(4096)) dut0 (
      .clk (clk), .reset (reset), .bus (b0));
   e_inv_sched #(.N_REQ(2), .WIDTH(256), .TIMEOUT(16)) dut1 (
      .clk (clk), .reset (reset), .bus (b1));

   always #5 clk = ~clk;

   // Inverter stubs: done is raised in the lat-th cycle of start being high (lat 0 = never).
   int          lat0 = 0, lat1 = 0;
   logic [255:0] res0 = 256'hABCD, res1 = 256'h1234;
   logic [15:0]  scnt0, scnt1;

   always @(posedge clk or posedge reset) begin
      if (reset) scnt0 <= '0;
      else scnt0 <= b0.inv_start ? scnt0 + 16'd1 : 16'd0;
   end
   always @(posedge clk or posedge reset) begin
      if (reset) scnt1 <= '0;
      else scnt1 <= b1.inv_start ? scnt1 + 16'd1 : 16'd0;
   end
   assign b0.inv_done   = b0.inv_start && (lat0 != 0) && (int'(scnt0) == lat0 - 1);
   assign b1.inv_done   = b1.inv_start && (lat1 != 0) && (int'(scnt1) == lat1 - 1);
   assign b0.inv_result = res0;
   assign b1.inv_result = res1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      $display("check %s: observed %0h expected %0h", tag, obs, exp);
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Step until the selected instance pulses rsp_valid; counts cycles with inv_start high.
   task automatic wait_rsp(input bit sel, input int budget, output int starts);
      int         cyc;
      logic [1:0] v;
      starts = 0;
      cyc    = 0;
      v      = sel ? b1.rsp_valid : b0.rsp_valid;
      while (v == 2'b00 && cyc < budget) begin
         tick();
         cyc++;
         v = sel ? b1.rsp_valid : b0.rsp_valid;
         if (sel ? b1.inv_start : b0.inv_start) starts++;
      end
      chk(sel ? "rsp_in_budget_u1" : "rsp_in_budget_u0", {255'd0, cyc < budget}, 256'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   int starts;

   initial begin
      b0.req = 2'b00; b0.req_operand = '0;
      b1.req = 2'b00; b1.req_operand = '0;
      tick();
      // Reset state
      chk("rst_rsp_valid", {254'd0, b0.rsp_valid}, 256'd0);
      chk("rst_inv_start", {255'd0, b0.inv_start}, 256'd0);
      chk("rst_busy", {255'd0, b0.busy}, 256'd0);
      chk("rst_rsp_err", {255'd0, b0.rsp_err}, 256'd0);
      chk("rst_inv_operand", b0.inv_operand, 256'd0);
      tick();
      reset = 1'b0;

      // 1: single requester, 20-cycle inverter
      lat0 = 20;
      b0.req_operand = {256'd0, 256'd32916636844272};
      b0.req = 2'b01;
      wait_rsp(1'b0, 100, starts);
      chk("t1_start_cycles", starts, 256'd20);
      chk("t1_inv_operand", b0.inv_operand, 256'd32916636844272);
      chk("t1_rsp_valid", {254'd0, b0.rsp_valid}, 256'd1);
      chk("t1_rsp_data", b0.rsp_data, 256'hABCD);
      chk("t1_rsp_err", {255'd0, b0.rsp_err}, 256'd0);
      b0.req = 2'b00;
      tick();
      chk("t1_pulse_end", {254'd0, b0.rsp_valid}, 256'd0);
      chk("t1_busy_low", {255'd0, b0.busy}, 256'd0);

      // 2: simultaneous requests after reset, 10-cycle inverter
      do_reset();
      lat0 = 10;
      b0.req_operand = {256'd7, 256'd5};
      b0.req = 2'b11;
      tick();
      chk("t2_first_operand", b0.inv_operand, 256'd5);
      chk("t2_first_start", {255'd0, b0.inv_start}, 256'd1);
      wait_rsp(1'b0, 100, starts);
      chk("t2_first_starts", starts, 256'd9);
      chk("t2_first_valid", {254'd0, b0.rsp_valid}, 256'd1);
      chk("t2_first_data", b0.rsp_data, 256'hABCD);
      b0.req = 2'b10;
      tick();
      chk("t2_gap_start", {255'd0, b0.inv_start}, 256'd0);
      chk("t2_gap_valid", {254'd0, b0.rsp_valid}, 256'd0);
      tick();
      chk("t2_second_start", {255'd0, b0.inv_start}, 256'd1);
      chk("t2_second_operand", b0.inv_operand, 256'd7);
      wait_rsp(1'b0, 100, starts);
      chk("t2_second_starts", starts, 256'd9);
      chk("t2_second_valid", {254'd0, b0.rsp_valid}, 256'd2);
      b0.req = 2'b00;
      tick();

      // 3: zero operand on requester 1
      b0.req_operand = {256'd0, 256'd5};
      b0.req = 2'b10;
      tick();
      chk("t3_valid", {254'd0, b0.rsp_valid}, 256'd2);
      chk("t3_data", b0.rsp_data, 256'd0);
      chk("t3_err", {255'd0, b0.rsp_err}, 256'd1);
      chk("t3_no_start", {255'd0, b0.inv_start}, 256'd0);
      b0.req = 2'b00;
      tick();
      chk("t3_pulse_end", {254'd0, b0.rsp_valid}, 256'd0);
      chk("t3_no_start_after", {255'd0, b0.inv_start}, 256'd0);

      // 4: watchdog on the 16-cycle instance, then a normal operation
      lat1 = 0;
      b1.req_operand = {256'd0, 256'd3};
      b1.req = 2'b01;
      wait_rsp(1'b1, 100, starts);
      chk("t4_start_cycles", starts, 256'd16);
      chk("t4_valid", {254'd0, b1.rsp_valid}, 256'd1);
      chk("t4_err", {255'd0, b1.rsp_err}, 256'd1);
      chk("t4_data", b1.rsp_data, 256'd0);
      b1.req = 2'b00;
      tick();
      lat1 = 5;
      b1.req_operand = {256'd0, 256'd9};
      b1.req = 2'b01;
      wait_rsp(1'b1, 100, starts);
      chk("t4_next_starts", starts, 256'd5);
      chk("t4_next_valid", {254'd0, b1.rsp_valid}, 256'd1);
      chk("t4_next_err", {255'd0, b1.rsp_err}, 256'd0);
      chk("t4_next_data", b1.rsp_data, 256'h1234);
      b1.req = 2'b00;
      tick();

      // 5: asynchronous reset 5 cycles into RUN, held request re-served
      lat0 = 0;
      b0.req_operand = {256'd0, 256'h55};
      b0.req = 2'b01;
      tick();
      chk("t5_running", {255'd0, b0.inv_start}, 256'd1);
      repeat (4) tick();
      #2;
      reset = 1'b1;
      #1;
      chk("t5_async_start", {255'd0, b0.inv_start}, 256'd0);
      chk("t5_async_busy", {255'd0, b0.busy}, 256'd0);
      tick();
      tick();
      chk("t5_no_valid", {254'd0, b0.rsp_valid}, 256'd0);
      reset = 1'b0;
      lat0 = 6;
      wait_rsp(1'b0, 100, starts);
      chk("t5_starts", starts, 256'd6);
      chk("t5_operand", b0.inv_operand, 256'h55);
      chk("t5_valid", {254'd0, b0.rsp_valid}, 256'd1);
      chk("t5_data", b0.rsp_data, 256'hABCD);
      b0.req = 2'b00;
      tick();

      // 6: both requesters held, 4-cycle inverter, six operations alternate
      do_reset();
      lat0 = 4;
      b0.req_operand = {256'd13, 256'd11};
      b0.req = 2'b11;
      for (int n = 0; n < 6; n++) begin
         wait_rsp(1'b0, 50, starts);
         chk($sformatf("t6_grant_%0d", n), {254'd0, b0.rsp_valid}, (n % 2 == 0) ? 256'd1 : 256'd2);
         chk($sformatf("t6_starts_%0d", n), starts, 256'd4);
         tick();
      end
      b0.req = 2'b00;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: observed expired expected finish");
      $fatal(1, "time limit");
   end
endmodule
